// File: rtl/truth_table_sweeper.sv
// truth_table_sweeper
//   Walks every input vector 0 .. 2^N_IN-1 of a stored truth table. Each
//   vector is held for HOLD_CYC cycles, and the function value is presented
//   alongside it. The ones and zeros seen during the sweep are tallied.
//
//   Optional feature: define TRUTH_TABLE_SWEEPER_CAPTURE_EN to build a
//   capture register that records the swept response bit by bit. Without
//   the macro, capture is tied to zero.
//
// Parameters
//   N_IN      number of function inputs (2..8)
//   HOLD_CYC  cycles each vector is held (1..255)
//   TT_INIT   truth table loaded at reset (bit k = F at vector k)
//
// Ports
//   clk        rising-edge clock
//   rst        synchronous active-high reset
//   cfg_we     truth-table write strobe (honoured only outside a sweep)
//   cfg_tt     new truth table
//   start      sweep request, sampled in IDLE
//   abort      terminates a sweep in progress
//   busy       high while sweeping
//   done       one-cycle pulse on sweep completion
//   vec        current input vector (MSB = A)
//   f          function value for vec, registered together with vec
//   vec_valid  high on the first hold cycle of each vector
//   ones_cnt   swept vectors with f = 1
//   zeros_cnt  swept vectors with f = 0
//   capture    captured response (zero unless the capture feature is built)
module truth_table_sweeper #(
  parameter int unsigned           N_IN     = 4,
  parameter int unsigned           HOLD_CYC = 1,
  parameter logic [(2**N_IN)-1:0]  TT_INIT  = 16'hAAF8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    cfg_we,
  input  logic [(2**N_IN)-1:0]    cfg_tt,
  input  logic                    start,
  input  logic                    abort,
  output logic                    busy,
  output logic                    done,
  output logic [N_IN-1:0]         vec,
  output logic                    f,
  output logic                    vec_valid,
  output logic [N_IN:0]           ones_cnt,
  output logic [N_IN:0]           zeros_cnt,
  output logic [(2**N_IN)-1:0]    capture
);

  localparam int unsigned     TT_W      = 2**N_IN;
  localparam logic [N_IN-1:0] VEC_LAST  = '1;
  localparam logic [N_IN-1:0] VEC_ONE   = N_IN'(1);
  localparam logic [N_IN:0]   CNT_ONE   = (N_IN+1)'(1);
  localparam logic [7:0]      HOLD_LAST = 8'(HOLD_CYC - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SWEEP,
    ST_DONE
  } state_t;

  state_t            state;
  state_t            state_nxt;
  logic [TT_W-1:0]   tt;
  logic [7:0]        hold_cnt;

  logic              hold_end;
  logic              last_step;
  logic              tt_wr;
  logic [TT_W-1:0]   tt_eff;
  logic              sweep_go;
  logic              tally;
  logic [N_IN-1:0]   vec_inc;

  always_comb begin
    hold_end  = (hold_cnt == HOLD_LAST);
    last_step = hold_end && (vec == VEC_LAST);
    tt_wr     = cfg_we && (state != ST_SWEEP);
    // A write coincident with start must already feed the first vector.
    tt_eff    = tt_wr ? cfg_tt : tt;
    sweep_go  = (state == ST_IDLE) && start;
    // The vector is tallied when its first hold cycle ends; an abort on that
    // same edge discards it.
    tally     = (state == ST_SWEEP) && vec_valid && !abort;
    vec_inc   = vec + VEC_ONE;
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    unique case (state)
      ST_IDLE:  if (start) state_nxt = ST_SWEEP;
      ST_SWEEP: begin
        if (abort)          state_nxt = ST_IDLE;
        else if (last_step) state_nxt = ST_DONE;
      end
      ST_DONE:  state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    busy = (state == ST_SWEEP);
    done = (state == ST_DONE);
  end

  // Datapath: table, vector stepping and tallies
  always_ff @(posedge clk) begin
    if (rst) begin
      tt        <= TT_INIT;
      vec       <= '0;
      f         <= TT_INIT[0];
      vec_valid <= 1'b0;
      hold_cnt  <= '0;
      ones_cnt  <= '0;
      zeros_cnt <= '0;
    end else begin
      vec_valid <= 1'b0;
      if (tt_wr) tt <= cfg_tt;
      if (tally) begin
        if (f) ones_cnt  <= ones_cnt + CNT_ONE;
        else   zeros_cnt <= zeros_cnt + CNT_ONE;
      end
      if (sweep_go) begin
        vec       <= '0;
        f         <= tt_eff[0];
        vec_valid <= 1'b1;
        hold_cnt  <= '0;
        ones_cnt  <= '0;
        zeros_cnt <= '0;
      end else if ((state == ST_SWEEP) && !abort && !last_step) begin
        if (hold_end) begin
          vec       <= vec_inc;
          f         <= tt[vec_inc];
          vec_valid <= 1'b1;
          hold_cnt  <= '0;
        end else begin
          hold_cnt  <= hold_cnt + 8'd1;
        end
      end
    end
  end

`ifdef TRUTH_TABLE_SWEEPER_CAPTURE_EN
  logic [TT_W-1:0] cap_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      cap_q <= '0;
    end else if (sweep_go) begin
      cap_q <= '0;
    end else if (tally) begin
      cap_q[vec] <= f;
    end
  end

  assign capture = cap_q;
`else
  assign capture = '0;
`endif

endmodule

// File: tb/tb_truth_table_sweeper.sv
module tb_truth_table_sweeper;

  localparam logic [15:0] TT_DEF = 16'hAAF8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst = 1'b1;
  logic        cfg_we = 1'b0;
  logic [15:0] cfg_tt = '0;
  logic        start = 1'b0;
  logic        abort = 1'b0;

  logic [1:0]       busy_w, done_w, f_w, vv_w;
  logic [1:0][3:0]  vec_w;
  logic [1:0][4:0]  ones_w, zeros_w;
  logic [1:0][15:0] cap_w;

  truth_table_sweeper #(.N_IN(4), .HOLD_CYC(1), .TT_INIT(TT_DEF)) u_dut_h1 (
    .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_tt(cfg_tt), .start(start), .abort(abort),
    .busy(busy_w[0]), .done(done_w[0]), .vec(vec_w[0]), .f(f_w[0]), .vec_valid(vv_w[0]),
    .ones_cnt(ones_w[0]), .zeros_cnt(zeros_w[0]), .capture(cap_w[0])
  );

  truth_table_sweeper #(.N_IN(4), .HOLD_CYC(3), .TT_INIT(TT_DEF)) u_dut_h3 (
    .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_tt(cfg_tt), .start(start), .abort(abort),
    .busy(busy_w[1]), .done(done_w[1]), .vec(vec_w[1]), .f(f_w[1]), .vec_valid(vv_w[1]),
    .ones_cnt(ones_w[1]), .zeros_cnt(zeros_w[1]), .capture(cap_w[1])
  );

  int n_total = 0;
  int n_bad   = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference model: a sweep is described by how many cycles k have elapsed
  // since it began; every visible value follows arithmetically from k, the
  // hold length and the table.
  bit          m_active [2];
  bit          m_done   [2];
  bit          m_valid  [2];
  bit          m_f      [2];
  int          m_k      [2];
  int          m_vec    [2];
  int          m_ones   [2];
  int          m_zeros  [2];
  logic [15:0] m_tt     [2];
  logic [15:0] m_cap    [2];

  function automatic int hold_of(input int d);
    return (d == 0) ? 1 : 3;
  endfunction

  task automatic m_eval(input int d);
    int h;
    int cnt;
    h   = hold_of(d);
    cnt = m_k[d] / h + (((m_k[d] % h) != 0) ? 1 : 0);
    if (cnt > 16) cnt = 16;
    m_vec[d] = m_k[d] / h;
    if (m_vec[d] > 15) m_vec[d] = 15;
    m_f[d]     = m_tt[d][m_vec[d]];
    m_valid[d] = ((m_k[d] % h) == 0) && (m_k[d] < 16 * h);
    m_ones[d]  = 0;
    m_cap[d]   = '0;
    for (int i = 0; i < cnt; i++) begin
      if (m_tt[d][i]) m_ones[d]++;
      m_cap[d][i] = m_tt[d][i];
    end
    m_zeros[d] = cnt - m_ones[d];
  endtask

  always @(posedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (rst) begin
        m_tt[d]     = TT_DEF;
        m_active[d] = 1'b0;
        m_done[d]   = 1'b0;
        m_k[d]      = 0;
        m_vec[d]    = 0;
        m_f[d]      = TT_DEF[0];
        m_valid[d]  = 1'b0;
        m_ones[d]   = 0;
        m_zeros[d]  = 0;
        m_cap[d]    = '0;
      end else if (m_active[d]) begin
        if (abort) begin
          m_active[d] = 1'b0;
          m_valid[d]  = 1'b0;
        end else begin
          m_k[d]++;
          m_eval(d);
          if (m_k[d] == 16 * hold_of(d)) begin
            m_active[d] = 1'b0;
            m_done[d]   = 1'b1;
          end
        end
      end else begin
        bit was_done;
        was_done  = m_done[d];
        m_done[d] = 1'b0;
        if (cfg_we) m_tt[d] = cfg_tt;
        if (!was_done && start) begin
          m_active[d] = 1'b1;
          m_k[d]      = 0;
          m_eval(d);
        end
      end
    end
  end

  int cyc = 0;
  int start_cyc = 0;
  int done_cyc [2];

  task automatic cmp_all();
    logic [15:0] cap_exp;
    for (int d = 0; d < 2; d++) begin
`ifdef TRUTH_TABLE_SWEEPER_CAPTURE_EN
      cap_exp = m_cap[d];
`else
      cap_exp = '0;
`endif
      check_val($sformatf("busy%0d@%0d", d, cyc),  busy_w[d],  m_active[d]);
      check_val($sformatf("done%0d@%0d", d, cyc),  done_w[d],  m_done[d]);
      check_val($sformatf("vec%0d@%0d", d, cyc),   vec_w[d],   m_vec[d]);
      check_val($sformatf("f%0d@%0d", d, cyc),     f_w[d],     m_f[d]);
      check_val($sformatf("vv%0d@%0d", d, cyc),    vv_w[d],    m_valid[d]);
      check_val($sformatf("ones%0d@%0d", d, cyc),  ones_w[d],  m_ones[d]);
      check_val($sformatf("zeros%0d@%0d", d, cyc), zeros_w[d], m_zeros[d]);
      check_val($sformatf("cap%0d@%0d", d, cyc),   cap_w[d],   cap_exp);
    end
  endtask

  task automatic step(input bit s, input bit a, input bit we, input logic [15:0] t, input bit r);
    start  = s;
    abort  = a;
    cfg_we = we;
    cfg_tt = t;
    rst    = r;
    @(negedge clk);
    cyc++;
    cmp_all();
    for (int d = 0; d < 2; d++) if (done_w[d]) done_cyc[d] = cyc;
  endtask

  task automatic idle(input int n);
    repeat (n) step(1'b0, 1'b0, 1'b0, 16'h0, 1'b0);
  endtask

  task automatic go(input bit we, input logic [15:0] t);
    done_cyc[0] = 0;
    done_cyc[1] = 0;
    start_cyc   = cyc;
    step(1'b1, 1'b0, we, t, 1'b0);
  endtask

  initial begin
    logic [15:0] cap_exp;

    // Reset
    step(1'b0, 1'b0, 1'b0, 16'h0, 1'b1);
    step(1'b1, 1'b1, 1'b1, 16'h5555, 1'b1);
    check_val("rst_busy", busy_w[0], 1'b0);
    check_val("rst_vec", vec_w[0], 4'd0);
    idle(2);

    // Default table sweep
    go(1'b0, 16'h0);
    check_val("first_vv", vv_w[0], 1'b1);
    idle(55);
    check_val("lat_h1", done_cyc[0] - start_cyc, 17);
    check_val("lat_h3", done_cyc[1] - start_cyc, 49);
    check_val("def_ones", ones_w[0], 5'd9);
    check_val("def_zeros", zeros_w[0], 5'd7);
    check_val("def_f_hold", f_w[0], 1'b1);

    // All-zero and all-one tables
    step(1'b0, 1'b0, 1'b1, 16'h0000, 1'b0);
    go(1'b0, 16'h0);
    idle(55);
    check_val("zero_ones", ones_w[0], 5'd0);
    check_val("zero_zeros", zeros_w[0], 5'd16);
    step(1'b0, 1'b0, 1'b1, 16'hFFFF, 1'b0);
    go(1'b0, 16'h0);
    idle(55);
    check_val("one_ones", ones_w[0], 5'd16);
    check_val("one_ones_h3", ones_w[1], 5'd16);

    // Abort at vec=5 with an ignored mid-sweep write
    step(1'b0, 1'b0, 1'b1, TT_DEF, 1'b0);
    go(1'b0, 16'h0);
    idle(2);
    step(1'b0, 1'b0, 1'b1, 16'h1234, 1'b0);
    idle(2);
    check_val("abort_at5", vec_w[0], 4'd5);
    step(1'b0, 1'b1, 1'b0, 16'h0, 1'b0);
    check_val("abort_busy", busy_w[0], 1'b0);
    check_val("abort_ones", ones_w[0], 5'd2);
    check_val("abort_zeros", zeros_w[0], 5'd3);
    idle(3);
    check_val("abort_nodone", done_cyc[0], 0);
    go(1'b0, 16'h0);
    idle(55);
    check_val("restart_ones", ones_w[0], 5'd9);

    // Write coincident with start
    go(1'b1, 16'h8001);
    idle(55);
`ifdef TRUTH_TABLE_SWEEPER_CAPTURE_EN
    cap_exp = 16'h8001;
`else
    cap_exp = 16'h0000;
`endif
    check_val("cap_final", cap_w[0], cap_exp);
    check_val("cap_ones", ones_w[0], 5'd2);

    // Reset mid-sweep at vec=9
    go(1'b0, 16'h0);
    idle(9);
    check_val("rst_at9", vec_w[0], 4'd9);
    step(1'b0, 1'b0, 1'b0, 16'h0, 1'b1);
    check_val("rst9_busy", busy_w[0], 1'b0);
    check_val("rst9_vec", vec_w[0], 4'd0);
    check_val("rst9_f", f_w[0], 1'b0);
    check_val("rst9_ones", ones_w[0], 5'd0);
    idle(20);
    check_val("rst9_nodone", done_cyc[0], 0);
    go(1'b0, 16'h0);
    idle(55);
    check_val("rst9_tt", ones_w[0], 5'd9);

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      step($urandom_range(0, 7) == 0, $urandom_range(0, 39) == 0,
           $urandom_range(0, 9) == 0, 16'($urandom), $urandom_range(0, 299) == 0);
    end
    step(1'b0, 1'b0, 1'b0, 16'h0, 1'b1);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
